// File: rtl/fft_bfly_pipe.sv
// fft_bfly_pipe: pipelined radix-2 butterfly, sum = A+B, dif = (A-B)*W, optional /2 scaling, saturation + ovf flag.
// Latency: 3 cycles from accepted input to out_valid; 1 sample per clock while out_ready is high.
// Backpressure: rigid 3-stage pipeline, every stage holds while out_valid & !out_ready; in_ready = !out_valid | out_ready.
// Build option: define FFT_BFLY_ROUND_EN for round-half-up on every right shift (default build truncates).
module fft_bfly_pipe #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_scale,
  input  logic [DW-1:0] a_re,
  input  logic [DW-1:0] a_im,
  input  logic [DW-1:0] b_re,
  input  logic [DW-1:0] b_im,
  input  logic [TW-1:0] w_re,
  input  logic [TW-1:0] w_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] sum_re,
  output logic [DW-1:0] sum_im,
  output logic [DW-1:0] dif_re,
  output logic [DW-1:0] dif_im,
  output logic          out_ovf
);
  // PW holds the full-precision complex product; MW holds one real partial product.
  localparam int PW = DW + TW + 2;
  localparam int MW = DW + TW + 1;

  logic                 en;
  // stage 1: exact add/sub, twiddle and scale
  logic                 v1_q, sc1_q;
  logic signed [DW:0]   sr1_q, si1_q, dr1_q, di1_q;
  logic signed [DW:0]   sr1_d, si1_d, dr1_d, di1_d;
  logic signed [TW-1:0] wr1_q, wi1_q;
  // stage 2: sum passthrough, complex product
  logic                 v2_q, sc2_q;
  logic signed [DW:0]   sr2_q, si2_q;
  logic signed [PW-1:0] pr2_q, pi2_q, pr2_d, pi2_d;
  logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
  // stage 3: shifted, scaled, saturated outputs
  logic                 v3_q, ovf_q, ovf_d;
  logic [DW-1:0]        sum_re_q, sum_im_q, dif_re_q, dif_im_q;
  logic [DW-1:0]        sum_re_d, sum_im_d, dif_re_d, dif_im_d;
  logic [DW:0]          o_sr, o_si, o_dr, o_di;

  // Arithmetic right shift by n; with rounding enabled, half an LSB is added first.
  function automatic logic signed [PW-1:0] shr_rnd(input logic signed [PW-1:0] x, input int n);
    logic signed [PW-1:0] y;
    y = x;
`ifdef FFT_BFLY_ROUND_EN
    y = y + (PW'(1) <<< (n - 1));
`endif
    return y >>> n;
  endfunction

  // Optional /2 then saturate to DW bits; returns {overflow, value}.
  function automatic logic [DW:0] post(input logic signed [PW-1:0] x, input logic scale);
    logic signed [PW-1:0] y;
    logic                 ovf;
    y   = scale ? shr_rnd(x, 1) : x;
    ovf = !((&y[PW-1:DW-1]) || !(|y[PW-1:DW-1]));
    if (ovf) return {1'b1, y[PW-1], {(DW-1){!y[PW-1]}}};
    return {1'b0, y[DW-1:0]};
  endfunction

  // One global advance: the whole pipeline moves unless the output is held.
  assign en        = !v3_q || out_ready;
  assign in_ready  = en;
  assign out_valid = v3_q;
  assign sum_re    = sum_re_q;
  assign sum_im    = sum_im_q;
  assign dif_re    = dif_re_q;
  assign dif_im    = dif_im_q;
  assign out_ovf   = ovf_q;

  // Stage 1 datapath: sign-extended exact sum and difference.
  always_comb begin
    sr1_d = {a_re[DW-1], a_re} + {b_re[DW-1], b_re};
    si1_d = {a_im[DW-1], a_im} + {b_im[DW-1], b_im};
    dr1_d = {a_re[DW-1], a_re} - {b_re[DW-1], b_re};
    di1_d = {a_im[DW-1], a_im} - {b_im[DW-1], b_im};
  end

  // Stage 1 register: capture a new sample only when one is offered and accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q  <= 1'b0;
      sc1_q <= 1'b0;
      sr1_q <= '0;
      si1_q <= '0;
      dr1_q <= '0;
      di1_q <= '0;
      wr1_q <= '0;
      wi1_q <= '0;
    end else if (en) begin
      v1_q <= in_valid;
      if (in_valid) begin
        sc1_q <= in_scale;
        sr1_q <= sr1_d;
        si1_q <= si1_d;
        dr1_q <= dr1_d;
        di1_q <= di1_d;
        wr1_q <= w_re;
        wi1_q <= w_im;
      end
    end
  end

  // Stage 2 datapath: four signed multipliers, full-precision complex product.
  always_comb begin
    m_rr  = MW'(dr1_q) * MW'(wr1_q);
    m_ii  = MW'(di1_q) * MW'(wi1_q);
    m_ri  = MW'(dr1_q) * MW'(wi1_q);
    m_ir  = MW'(di1_q) * MW'(wr1_q);
    pr2_d = PW'(m_rr) - PW'(m_ii);
    pi2_d = PW'(m_ri) + PW'(m_ir);
  end

  // Stage 2 register: bubbles are overwritten like real samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2_q  <= 1'b0;
      sc2_q <= 1'b0;
      sr2_q <= '0;
      si2_q <= '0;
      pr2_q <= '0;
      pi2_q <= '0;
    end else if (en) begin
      v2_q  <= v1_q;
      sc2_q <= sc1_q;
      sr2_q <= sr1_q;
      si2_q <= si1_q;
      pr2_q <= pr2_d;
      pi2_q <= pi2_d;
    end
  end

  // Stage 3 datapath: drop the Q1.(TW-1) fraction, optional /2, saturate, merge overflow.
  always_comb begin
    o_sr     = post(PW'(sr2_q), sc2_q);
    o_si     = post(PW'(si2_q), sc2_q);
    o_dr     = post(shr_rnd(pr2_q, TW - 1), sc2_q);
    o_di     = post(shr_rnd(pi2_q, TW - 1), sc2_q);
    sum_re_d = o_sr[DW-1:0];
    sum_im_d = o_si[DW-1:0];
    dif_re_d = o_dr[DW-1:0];
    dif_im_d = o_di[DW-1:0];
    ovf_d    = o_sr[DW] | o_si[DW] | o_dr[DW] | o_di[DW];
  end

  // Stage 3 register: drives the outputs directly, so they stay stable during a stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v3_q     <= 1'b0;
      ovf_q    <= 1'b0;
      sum_re_q <= '0;
      sum_im_q <= '0;
      dif_re_q <= '0;
      dif_im_q <= '0;
    end else if (en) begin
      v3_q     <= v2_q;
      ovf_q    <= ovf_d;
      sum_re_q <= sum_re_d;
      sum_im_q <= sum_im_d;
      dif_re_q <= dif_re_d;
      dif_im_q <= dif_im_d;
    end
  end

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// tb_fft_bfly_pipe: randomized and directed stimulus against an integer reference model of the butterfly.
// Checks reset state, 3-cycle latency, stall holding, in_ready behaviour, ordering and mid-stream reset.
// Rounding expectations follow FFT_BFLY_ROUND_EN when it is defined for the build.
module tb_fft_bfly_pipe;
  localparam int DW = 16;
  localparam int TW = 16;
`ifdef FFT_BFLY_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic          clk, rstn;
  logic          in_valid, in_ready, in_scale;
  logic [DW-1:0] a_re, a_im, b_re, b_im;
  logic [TW-1:0] w_re, w_im;
  logic          out_valid, out_ready, out_ovf;
  logic [DW-1:0] sum_re, sum_im, dif_re, dif_im;
  logic [4*DW:0] out_vec;

  logic [4*DW:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            out_cnt  = 0;
  bit            rnd_done = 1'b0;
  logic          hold_vld;
  logic [4*DW:0] hold_val;

  assign out_vec = {sum_re, sum_im, dif_re, dif_im, out_ovf};

  fft_bfly_pipe #(.DW(DW), .TW(TW)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_scale(in_scale),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_re(sum_re), .sum_im(sum_im), .dif_re(dif_re), .dif_im(dif_im),
    .out_ovf(out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: right shift by n, floor semantics, optional half-up rounding.
  function automatic longint shr(input longint x, input int n);
    longint y;
    y = x;
    if (RND) y = y + (longint'(1) << (n - 1));
    return y >>> n;
  endfunction

  function automatic logic [64:0] pack(input int sr, input int si, input int dr, input int di, input bit ov);
    return {16'(sr), 16'(si), 16'(dr), 16'(di), ov};
  endfunction

  function automatic logic [64:0] model(input logic [15:0] ar, input logic [15:0] ai,
                                        input logic [15:0] br, input logic [15:0] bi,
                                        input logic [15:0] wr, input logic [15:0] wi,
                                        input logic sc);
    longint   v[4];
    longint   dr, di, wre, wim;
    int       r[4];
    bit       ov;
    dr   = longint'($signed(ar)) - longint'($signed(br));
    di   = longint'($signed(ai)) - longint'($signed(bi));
    wre  = longint'($signed(wr));
    wim  = longint'($signed(wi));
    v[0] = longint'($signed(ar)) + longint'($signed(br));
    v[1] = longint'($signed(ai)) + longint'($signed(bi));
    v[2] = shr(dr * wre - di * wim, TW - 1);
    v[3] = shr(dr * wim + di * wre, TW - 1);
    ov   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (sc) v[i] = shr(v[i], 1);
      if (v[i] > 32767) begin
        r[i] = 32767;
        ov   = 1'b1;
      end else if (v[i] < -32768) begin
        r[i] = -32768;
        ov   = 1'b1;
      end else begin
        r[i] = int'(v[i]);
      end
    end
    return pack(r[0], r[1], r[2], r[3], ov);
  endfunction

  function automatic int rnd16();
    if ($urandom_range(0, 7) == 0) return ($urandom_range(0, 1) != 0) ? 32767 : 32768;
    return int'($urandom_range(0, 65535));
  endfunction

  // Offer one sample and return one cycle after it was accepted (in_valid already dropped).
  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input int wr, input int wi, input logic sc);
    int k;
    bit ok;
    a_re = 16'(ar); a_im = 16'(ai); b_re = 16'(br); b_im = 16'(bi);
    w_re = 16'(wr); w_im = 16'(wi); in_scale = sc; in_valid = 1'b1;
    ok = 1'b0;
    k  = 0;
    while (!ok && k < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      k++;
    end
    check("accept", 65'(ok), 65'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Single sample into an empty pipeline with out_ready high: check latency and exact result.
  task automatic directed(input string tag, input int ar, input int ai, input int br, input int bi,
                          input int wr, input int wi, input logic sc, input logic [64:0] exp);
    int lat;
    send(ar, ai, br, bi, wr, wi, sc);
    lat = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
    end
    check({tag, "_latency"}, 65'(lat), 65'(3));
    check({tag, "_value"}, out_vec, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("drain_empty", 65'(exp_q.size()), 65'(0));
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard, in_ready rule and output stability while stalled.
  initial begin
    hold_vld = 1'b0;
    hold_val = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        exp_q.delete();
        hold_vld = 1'b0;
      end else begin
        check("in_ready_rule", 65'(in_ready), 65'(!out_valid || out_ready));
        if (hold_vld) begin
          check("hold_valid", 65'(out_valid), 65'(1));
          check("hold_data", out_vec, hold_val);
        end
        hold_vld = out_valid && !out_ready;
        hold_val = out_vec;
        if (in_valid && in_ready)
          exp_q.push_back(model(a_re, a_im, b_re, b_im, w_re, w_im, in_scale));
        if (out_valid && out_ready) begin
          check("sb_expected_pending", 65'(exp_q.size() != 0), 65'(1));
          if (exp_q.size() != 0) check("scoreboard", out_vec, exp_q.pop_front());
          out_cnt++;
        end
      end
    end
  end

  initial begin
    int base;
    rstn = 1'b0; in_valid = 1'b0; in_scale = 1'b0; out_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    #2;
    check("rst_out_valid", 65'(out_valid), 65'(0));
    check("rst_in_ready", 65'(in_ready), 65'(1));
    check("rst_outputs", out_vec, 65'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases from known arithmetic
    directed("t_q15", 1000, -2000, 200, 400, 32767, 0, 1'b1,
             RND ? pack(600, -800, 400, -1200, 0) : pack(600, -800, 399, -1200, 0));
    directed("t_sat", 32767, 0, 32767, 0, 32767, 0, 1'b0, pack(32767, 0, 0, 0, 1));
    directed("t_sat_scaled", 32767, 0, 32767, 0, 32767, 0, 1'b1, pack(32767, 0, 0, 0, 0));
    directed("t_wneg", 100, 50, 0, 0, 32768, 0, 1'b0, pack(100, 50, -100, -50, 0));
    directed("t_round", 3, -3, 0, 0, 32767, 0, 1'b1,
             RND ? pack(2, -1, 2, -1, 0) : pack(1, -2, 1, -2, 0));
    directed("t_negsat", -32768, -32768, 32767, 32767, 32768, 32768, 1'b0,
             model(16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 1'b0));

    // Eight back-to-back samples with a 3-cycle stall on the fourth output
    base = out_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'($urandom_range(0, 1)));
      end
      begin
        int k, low;
        k = 0;
        low = 0;
        while (out_cnt < base + 3 && k < 100) begin
          @(posedge clk);
          k++;
        end
        check("stall_reached", 65'(out_cnt >= base + 3), 65'(1));
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!in_ready) low++;
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("stall_in_ready_low_cycles", 65'(low), 65'(3));
        check("stall_in_ready_back", 65'(in_ready), 65'(1));
      end
    join
    drain();
    check("stall_out_count", 65'(out_cnt - base), 65'(8));

    // Random stream with random gaps and random backpressure
    base = out_cnt;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'($urandom_range(0, 1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    check("random_out_count", 65'(out_cnt - base), 65'(300));

    // Asynchronous reset with samples in flight
    send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
    send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'b1);
    send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
    @(negedge clk);
    check("pre_rst_out_valid", 65'(out_valid), 65'(1));
    #2 rstn = 1'b0;
    #1;
    check("async_rst_out_valid", 65'(out_valid), 65'(0));
    check("async_rst_in_ready", 65'(in_ready), 65'(1));
    check("async_rst_outputs", out_vec, 65'(0));
    @(negedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    directed("t_after_rst", 1000, -2000, 200, 400, 32767, 0, 1'b1,
             RND ? pack(600, -800, 400, -1200, 0) : pack(600, -800, 399, -1200, 0));
    drain();
    check("no_stray_output", 65'(out_valid), 65'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
